// File: rtl/product_accumulator.sv
// product_accumulator: sums batches of COUNT products into an AW-bit total with valid/ready handshakes (`PRODUCT_ACCUMULATOR_SATURATE_EN clamps on overflow instead of wrapping)
module product_accumulator #(
  parameter int PW = 4,
  parameter int AW = 8,
  parameter int COUNT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_product,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_sum,
  output logic          out_overflow,
  output logic          busy
);
  typedef enum logic {ACCUM, HOLD} state_t;
  state_t state, state_nx;
  logic [AW-1:0] acc, acc_nx, add_res;
  logic [7:0] cnt, cnt_nx;
  logic ovf, ovf_nx;
  logic [AW:0] sum;
  logic take;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACCUM;
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else begin
      state <= state_nx;
      acc <= acc_nx;
      cnt <= cnt_nx;
      ovf <= ovf_nx;
    end
  end
  always_comb begin
    in_ready = state == ACCUM && !flush;
    out_valid = state == HOLD;
    take = in_valid && in_ready;
    sum = {1'b0, acc} + (AW+1)'(in_product);
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
    add_res = sum[AW] ? '1 : sum[AW-1:0];
`else
    add_res = sum[AW-1:0];
`endif
    state_nx = state;
    acc_nx = acc;
    cnt_nx = cnt;
    ovf_nx = ovf;
    if (state == ACCUM) begin
      if (flush) begin
        acc_nx = '0;
        cnt_nx = '0;
        ovf_nx = 1'b0;
      end else if (take) begin
        acc_nx = add_res;
        cnt_nx = cnt + 8'd1;
        ovf_nx = ovf | sum[AW];
        state_nx = cnt == 8'(COUNT - 1) ? HOLD : ACCUM;
      end
    end else if (out_ready) begin
      acc_nx = '0;
      cnt_nx = '0;
      ovf_nx = 1'b0;
      state_nx = ACCUM;
    end
  end
  assign out_sum = acc;
  assign out_overflow = ovf;
  assign busy = state == HOLD || cnt != 8'd0;
endmodule

// File: tb/tb_product_accumulator.sv
// tb_product_accumulator: random and directed checks of two accumulator configurations against a batch-level model
module tb_product_accumulator;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1;
  logic [1:0] iv = '0, fl = '0, ordy = '0, ir, ovld, ovf, bsy;
  logic [3:0] pr0 = '0, pr1 = '0;
  logic [7:0] sum0;
  logic [3:0] sum1;
  int pass_n = 0, tot_n = 0;
  bit started = 0;
  bit hold [2] = '{0, 0};
  bit mov [2] = '{0, 0};
  int n [2] = '{0, 0};
  int acc [2] = '{0, 0};
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  product_accumulator u_main (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_product(pr0),
    .flush(fl[0]), .out_valid(ovld[0]), .out_ready(ordy[0]), .out_sum(sum0),
    .out_overflow(ovf[0]), .busy(bsy[0])
  );
  product_accumulator #(.PW(4), .AW(4), .COUNT(2)) u_small (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_product(pr1),
    .flush(fl[1]), .out_valid(ovld[1]), .out_ready(ordy[1]), .out_sum(sum1),
    .out_overflow(ovf[1]), .busy(bsy[1])
  );
  task automatic chk(input string nm, input int act, input int exp);
    tot_n++;
    if (act == exp) pass_n++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask
  always @(posedge clk) begin
    int p, t, lim, cnt;
    for (int k = 0; k < 2; k++) begin
      p = k ? int'(pr1) : int'(pr0);
      lim = k ? 15 : 255;
      cnt = k ? 2 : 4;
      if (rst || (hold[k] && ordy[k]) || (!hold[k] && fl[k])) begin
        hold[k] = 0;
        n[k] = 0;
        acc[k] = 0;
        mov[k] = 0;
      end else if (!hold[k] && iv[k]) begin
        t = acc[k] + p;
        if (t > lim) begin
          mov[k] = 1;
          t = SAT ? lim : t % (lim + 1);
        end
        acc[k] = t;
        n[k]++;
        if (n[k] == cnt) hold[k] = 1;
      end
    end
  end
  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("in_ready%0d", k), int'(ir[k]), int'(!hold[k] && !fl[k]));
        chk($sformatf("out_valid%0d", k), int'(ovld[k]), int'(hold[k]));
        chk($sformatf("busy%0d", k), int'(bsy[k]), int'(hold[k] || n[k] > 0));
        chk($sformatf("overflow%0d", k), int'(ovf[k]), int'(mov[k]));
      end
      chk("out_sum0", int'(sum0), acc[0]);
      chk("out_sum1", int'(sum1), acc[1]);
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic put(input int p);
    iv[0] = 1'b1;
    pr0 = 4'(p);
    tick();
  endtask
  task automatic reset_vals(input string nm);
    chk({nm, "_ready"}, int'(ir[0]), 1);
    chk({nm, "_valid"}, int'(ovld[0]), 0);
    chk({nm, "_sum"}, int'(sum0), 0);
    chk({nm, "_ovf"}, int'(ovf[0]), 0);
    chk({nm, "_busy"}, int'(bsy[0]), 0);
  endtask
  initial begin
    tick();
    reset_vals("reset");
    started = 1;
    rst = 1'b0;
    ordy = 2'b11;
    put(0); put(1); put(4); put(9);
    iv[0] = 1'b0;
    chk("basic_valid", int'(ovld[0]), 1);
    chk("basic_sum", int'(sum0), 14);
    chk("basic_ovf", int'(ovf[0]), 0);
    tick();
    chk("basic_resume", int'(ir[0]), 1);
    ordy[0] = 1'b0;
    put(0); put(1); put(4); put(9);
    tick(); tick(); tick();
    chk("bp_ready", int'(ir[0]), 0);
    chk("bp_sum", int'(sum0), 14);
    ordy[0] = 1'b1;
    tick();
    chk("bp_deliver", int'(ovld[0]), 0);
    chk("bp_idle", int'(bsy[0]), 0);
    tick();
    chk("bp_take9", int'(sum0), 9);
    put(0); put(0); put(0);
    iv[0] = 1'b0;
    chk("bp_sum9", int'(sum0), 9);
    tick();
    put(4);
    iv[0] = 1'b0;
    tick(); tick();
    put(4);
    iv[0] = 1'b0;
    tick();
    put(1); put(1);
    iv[0] = 1'b0;
    chk("gap_sum", int'(sum0), 10);
    tick();
    ordy[0] = 1'b0;
    put(9); put(9);
    fl[0] = 1'b1;
    put(4);
    fl[0] = 1'b0;
    chk("flush_cleared", int'(sum0), 0);
    put(1); put(1); put(1); put(1);
    iv[0] = 1'b0;
    chk("flush_sum", int'(sum0), 4);
    chk("flush_ovf", int'(ovf[0]), 0);
    fl[0] = 1'b1;
    tick();
    fl[0] = 1'b0;
    chk("hold_flush_sum", int'(sum0), 4);
    chk("hold_flush_valid", int'(ovld[0]), 1);
    ordy[0] = 1'b1;
    tick();
    put(9); put(9);
    iv[0] = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    reset_vals("midrst");
    put(1); put(1); put(1); put(1);
    iv[0] = 1'b0;
    chk("midrst_sum", int'(sum0), 4);
    tick();
    iv[1] = 1'b1;
    pr1 = 4'd9;
    tick(); tick();
    iv[1] = 1'b0;
    chk("ovf_sum", int'(sum1), SAT ? 15 : 2);
    chk("ovf_flag", int'(ovf[1]), 1);
    tick();
    repeat (3000) begin
      rst = $urandom_range(99) == 0;
      iv = 2'($urandom);
      fl = {1'($urandom_range(9) == 0), 1'($urandom_range(9) == 0)};
      ordy = {1'($urandom_range(2) != 0), 1'($urandom_range(2) != 0)};
      pr0 = 4'($urandom);
      pr1 = 4'($urandom);
      tick();
    end
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule
